// File: rtl/sync_fifo_arb_pkg.sv
//------------------------------------------------------------------------------
// Module   : sync_fifo_arb_pkg
// Purpose  : Shared constants and the round-robin search helper used by the
//            FIFO write arbiter and its pointer sub-module.
// Contents : PTR_W, ID_W     - width helpers for the default configuration
//            MAX_REQ         - largest supported producer count
//            rr_next()       - returns {found, idx} for a round-robin search
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package sync_fifo_arb_pkg;

  localparam int DEF_DATA_DEPTH = 16;
  localparam int DEF_NUM_REQ    = 4;

  localparam int PTR_W = $clog2(DEF_DATA_DEPTH);
  localparam int ID_W  = $clog2(DEF_NUM_REQ);

  // The search helper works on a fixed 8-wide vector; callers zero-extend.
  localparam int MAX_REQ  = 8;
  localparam int RR_IDX_W = 3;

  // Scan last+1, last+2, ... modulo n and return the first valid index.
  // Result is {found, idx}; idx is 0 when nothing is valid.
  function automatic logic [RR_IDX_W:0] rr_next(
    input logic [MAX_REQ-1:0]  valid,
    input logic [RR_IDX_W-1:0] last,
    input int unsigned         n
  );
    logic [RR_IDX_W:0] res;
    int unsigned       idx;
    res = '0;
    for (int unsigned k = 1; k <= MAX_REQ; k++) begin
      if (k <= n) begin
        idx = (int'(last) + k) % n;
        if (!res[RR_IDX_W] && valid[idx]) begin
          res = {1'b1, idx[RR_IDX_W-1:0]};
        end
      end
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
//------------------------------------------------------------------------------
// Module   : rr_arbiter
// Purpose  : Round-robin candidate search plus the "last accepted" pointer.
// Ports    : clk, rst_n          - clock, async active-low reset
//            valid[NUM_REQ]      - request vector
//            update, update_idx  - load pointer with update_idx on a transfer
//            cand_found/cand_idx - first valid requester after the pointer
//            last                - current pointer value
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
  import sync_fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         valid,
  input  logic                       update,
  input  logic [$clog2(NUM_REQ)-1:0] update_idx,
  output logic                       cand_found,
  output logic [$clog2(NUM_REQ)-1:0] cand_idx,
  output logic [$clog2(NUM_REQ)-1:0] last
);

  localparam int c_id_w = $clog2(NUM_REQ);

  logic [c_id_w-1:0]   r_last;
  logic [MAX_REQ-1:0]  w_valid_ext;
  logic [RR_IDX_W:0]   w_search;

  always_comb begin
    w_valid_ext                = '0;
    w_valid_ext[NUM_REQ-1:0]   = valid;
  end

  assign w_search   = rr_next(w_valid_ext, RR_IDX_W'(r_last), NUM_REQ);
  assign cand_found = w_search[RR_IDX_W];
  assign cand_idx   = c_id_w'(w_search[RR_IDX_W-1:0]);
  assign last       = r_last;

  // Reset to the highest index so producer 0 is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= c_id_w'(NUM_REQ - 1);
    end else if (update) begin
      r_last <= update_idx;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sync_fifo_wr_arb.sv
//------------------------------------------------------------------------------
// Module   : sync_fifo_wr_arb
// Purpose  : Round-robin write arbiter sharing one synchronous FIFO write port
//            among NUM_REQ valid/ready producers. Keeps its own occupancy
//            count so accepted beats can never overflow the FIFO despite the
//            registered write stage.
// Ports    : clk, rst_n           - clock, async active-low reset
//            req_valid/req_data   - producer i data at [i*DATA_WIDTH +: DATA_WIDTH]
//            req_ready            - one-hot or zero, combinational
//            fifo_wr_en/fifo_data - registered FIFO write port
//            fifo_rd_en/fifo_empty- FIFO read side, observed only
//            grant_id             - last accepted producer (registered)
//            level                - committed occupancy
// Config   : define SYNC_FIFO_ARB_BURST_EN to keep a grant for up to BURST_LEN
//            consecutive beats; otherwise pure per-beat round-robin.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sync_fifo_wr_arb
  import sync_fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int BURST_LEN  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  input  logic                          fifo_rd_en,
  input  logic                          fifo_empty,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic [$clog2(DATA_DEPTH):0]   level
);

  localparam int c_id_w  = $clog2(NUM_REQ);
  localparam int c_lvl_w = $clog2(DATA_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] w_data_arr [NUM_REQ];
  logic                  w_cand_found;
  logic [c_id_w-1:0]     w_cand_idx;
  logic [c_id_w-1:0]     w_last;
  logic                  w_sel_found;
  logic [c_id_w-1:0]     w_sel_idx;
  logic                  w_space;
  logic                  w_inc;
  logic                  w_dec;

  logic                  r_wr_en;
  logic [DATA_WIDTH-1:0] r_data;
  logic [c_id_w-1:0]     r_grant;
  logic [c_lvl_w-1:0]    r_level;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_arbiter #(
    .NUM_REQ    (NUM_REQ)
  ) u_rr (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid      (req_valid),
    .update     (w_inc),
    .update_idx (w_sel_idx),
    .cand_found (w_cand_found),
    .cand_idx   (w_cand_idx),
    .last       (w_last)
  );

`ifdef SYNC_FIFO_ARB_BURST_EN
  localparam int c_cnt_w = $clog2(BURST_LEN) + 1;

  logic [c_cnt_w-1:0] r_burst_cnt;
  logic               w_hold;

  // A non-zero count means the producer at w_last owns an unfinished burst.
  assign w_hold      = (r_burst_cnt != '0) && req_valid[w_last] &&
                       (r_burst_cnt < c_cnt_w'(BURST_LEN));
  assign w_sel_found = w_hold | w_cand_found;
  assign w_sel_idx   = w_hold ? w_last : w_cand_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_burst_cnt <= '0;
    end else if (w_inc) begin
      if (!w_hold) begin
        // Fresh grant from the round-robin search starts a new burst.
        r_burst_cnt <= (BURST_LEN > 1) ? c_cnt_w'(1) : '0;
      end else if ((r_burst_cnt + c_cnt_w'(1)) >= c_cnt_w'(BURST_LEN)) begin
        r_burst_cnt <= '0;
      end else begin
        r_burst_cnt <= r_burst_cnt + c_cnt_w'(1);
      end
    end else if ((r_burst_cnt != '0) && !req_valid[w_last]) begin
      r_burst_cnt <= '0;
    end
  end
`else
  logic w_unused_burst_len;
  assign w_unused_burst_len = (BURST_LEN > 0);
  assign w_sel_found        = w_cand_found;
  assign w_sel_idx          = w_cand_idx;
`endif

  // Readiness uses the committed level rather than the FIFO full flag, since
  // level already counts the beat sitting in the write register.
  assign w_space = (r_level < c_lvl_w'(DATA_DEPTH));

  always_comb begin
    req_ready = '0;
    if (w_sel_found && w_space) begin
      req_ready[w_sel_idx] = 1'b1;
    end
  end

  assign w_inc = w_sel_found && w_space && req_valid[w_sel_idx];
  assign w_dec = fifo_rd_en && !fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en <= 1'b0;
      r_data  <= '0;
      r_grant <= '0;
    end else begin
      r_wr_en <= w_inc;
      if (w_inc) begin
        r_data  <= w_data_arr[w_sel_idx];
        r_grant <= w_sel_idx;
      end
    end
  end

  // A read at level 0 is a protocol error; the count saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= '0;
    end else if (w_inc && !w_dec) begin
      r_level <= r_level + c_lvl_w'(1);
    end else if (!w_inc && w_dec && (r_level != '0)) begin
      r_level <= r_level - c_lvl_w'(1);
    end
  end

  assign fifo_wr_en = r_wr_en;
  assign fifo_data  = r_data;
  assign grant_id   = r_grant;
  assign level      = r_level;

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_wr_arb.sv
//------------------------------------------------------------------------------
// Module   : tb_sync_fifo_wr_arb
// Purpose  : Directed self-checking bench for sync_fifo_wr_arb (default
//            parameters). Burst ordering is exercised when
//            SYNC_FIFO_ARB_BURST_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sync_fifo_wr_arb;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_wr_en;
  logic [7:0]  fifo_data;
  logic        fifo_rd_en;
  logic        fifo_empty;
  logic [1:0]  grant_id;
  logic [4:0]  level;

  int checks   = 0;
  int failures = 0;

  sync_fifo_wr_arb #(
    .DATA_WIDTH (8),
    .DATA_DEPTH (16),
    .NUM_REQ    (4),
    .BURST_LEN  (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_wr_en (fifo_wr_en),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .fifo_empty (fifo_empty),
    .grant_id   (grant_id),
    .level      (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid  = '0;
    fifo_rd_en = 1'b0;
    fifo_empty = 1'b0;
    rst_n      = 1'b0;
    #2;
    rst_n      = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_data   = '0;
    fifo_rd_en = 1'b0;
    fifo_empty = 1'b0;
    #2;
    check("rst_wr_en", 32'(fifo_wr_en), 32'h0);
    check("rst_data",  32'(fifo_data),  32'h0);
    check("rst_grant", 32'(grant_id),   32'h0);
    check("rst_level", 32'(level),      32'h0);
    check("rst_ready", 32'(req_ready),  32'h0);
    #10;
    rst_n = 1'b1;

    // Single producer 2
    req_valid = 4'b0100;
    req_data  = 32'h00A5_0000;
    #1;
    check("p2_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    check("p2_wr_en", 32'(fifo_wr_en), 32'h1);
    check("p2_data",  32'(fifo_data),  32'hA5);
    check("p2_grant", 32'(grant_id),   32'h2);
    check("p2_level", 32'(level),      32'h1);
    tick();
    check("p2_idle_wr_en", 32'(fifo_wr_en), 32'h0);
    check("p2_idle_data",  32'(fifo_data),  32'hA5);

    // Read on an empty FIFO flag does not decrement
    fifo_rd_en = 1'b1;
    fifo_empty = 1'b1;
    tick();
    check("empty_rd_level", 32'(level), 32'h1);
    fifo_rd_en = 1'b0;
    fifo_empty = 1'b0;

    // Underflow: read at level 0 saturates
    do_reset();
    fifo_rd_en = 1'b1;
    tick();
    check("underflow_level", 32'(level), 32'h0);
    fifo_rd_en = 1'b0;

    req_data = 32'h1312_1110;

`ifndef SYNC_FIFO_ARB_BURST_EN
    // All producers valid, no reads: 0,1,2,3,... until full
    do_reset();
    req_valid = 4'b1111;
    for (int n = 0; n < 16; n++) begin
      #1;
      check("rr_ready", 32'(req_ready), 32'(1 << (n % 4)));
      tick();
      check("rr_grant", 32'(grant_id), 32'(n % 4));
      check("rr_data",  32'(fifo_data), 32'(8'h10 + (n % 4)));
      check("rr_level", 32'(level), 32'(n + 1));
    end
    check("full_ready", 32'(req_ready), 32'h0);
    tick();
    check("full_wr_en", 32'(fifo_wr_en), 32'h0);
    check("full_level", 32'(level), 32'd16);

    // One read frees exactly one slot, visible next cycle
    fifo_rd_en = 1'b1;
    #1;
    check("rd_no_comb_path", 32'(req_ready), 32'h0);
    tick();
    fifo_rd_en = 1'b0;
    check("rd_level", 32'(level), 32'd15);
    #1;
    check("rd_ready", 32'(req_ready), 32'h1);
    tick();
    check("refill_level", 32'(level), 32'd16);
    check("refill_grant", 32'(grant_id), 32'h0);
    check("refill_wr_en", 32'(fifo_wr_en), 32'h1);
    #1;
    check("refill_ready", 32'(req_ready), 32'h0);

    // Drain to 8, then simultaneous accept and read
    req_valid  = '0;
    fifo_rd_en = 1'b1;
    for (int n = 0; n < 8; n++) tick();
    check("drain_level", 32'(level), 32'd8);
    req_valid = 4'b0010;
    tick();
    req_valid  = '0;
    fifo_rd_en = 1'b0;
    check("rw_level", 32'(level),      32'd8);
    check("rw_wr_en", 32'(fifo_wr_en), 32'h1);
    check("rw_grant", 32'(grant_id),   32'h1);
    check("rw_data",  32'(fifo_data),  32'h11);
`else
    // Burst: producers 0 and 1 continuously valid
    begin
      logic [1:0] exp_order [9];
      exp_order = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
      do_reset();
      req_valid = 4'b0011;
      for (int n = 0; n < 9; n++) begin
        tick();
        check("burst_grant", 32'(grant_id), 32'(exp_order[n]));
      end
      req_valid = '0;
    end
`endif

    // Reset mid-operation with a write in flight
    do_reset();
    req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) tick();
    check("pre_rst_level", 32'(level), 32'd5);
    check("pre_rst_wr_en", 32'(fifo_wr_en), 32'h1);
    rst_n = 1'b0;
    #1;
    check("async_rst_wr_en", 32'(fifo_wr_en), 32'h0);
    check("async_rst_level", 32'(level),      32'h0);
    check("async_rst_grant", 32'(grant_id),   32'h0);
    check("async_rst_data",  32'(fifo_data),  32'h0);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", 32'(req_ready), 32'h1);
    tick();
    check("post_rst_grant", 32'(grant_id), 32'h0);
    check("post_rst_level", 32'(level),    32'h1);
    req_valid = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
